// File: rtl/bit_serial_sequencer.sv
// bit_serial_sequencer: decode/execute sequencer for the bit-serial CPU; define SEQ_SINGLE_STEP_EN to advance EXEC one bit per btn_edge
module bit_serial_sequencer #(
  parameter int WIDTH  = 8,
  parameter int REG_AW = 3
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [11:0]                instr,
  input  logic                       instr_valid,
  input  logic                       btn_edge,
  output logic [1:0]                 alu_op,
  output logic                       carry_clr,
  output logic                       carry_set,
  output logic [REG_AW-1:0]          reg_addr_sel,
  output logic                       reg_shift_en,
  output logic                       reg_write_en,
  output logic                       acc_shift_en,
  output logic                       acc_recirc,
  output logic                       acc_write_en,
  output logic [7:0]                 imm,
  output logic [$clog2(WIDTH)-1:0]   bit_idx,
  output logic                       busy,
  output logic                       done,
  output logic                       illegal
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, DONE} state_t;
  state_t state, state_n;
  logic [11:0] instr_q;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] op;
  logic is_exec, is_st, step, ex, last;
  assign op      = instr_q[11:8];
  assign is_exec = op != 4'd0 && op < 4'd6;
  assign is_st   = op == 4'd5;
  assign last    = cnt == CW'(WIDTH - 1);
`ifdef SEQ_SINGLE_STEP_EN
  assign step = btn_edge;
`else
  assign step = 1'b1;
`endif
  assign ex = state == EXEC && step;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      instr_q <= '0;
      cnt     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && btn_edge && instr_valid) instr_q <= instr;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    case (state)
      IDLE:   state_n = (btn_edge && instr_valid) ? DECODE : IDLE;
      DECODE: state_n = is_exec ? EXEC : DONE;
      EXEC: begin
        cnt_n   = (step && !last) ? cnt + CW'(1) : (step ? '0 : cnt);
        state_n = (step && last) ? DONE : EXEC;
      end
      default: state_n = IDLE;
    endcase
  end
  // op-1 maps ADD/SUB/AND/OR (1..4) onto alu codes 00..11
  assign alu_op       = (state == EXEC && !is_st) ? op[1:0] - 2'd1 : 2'd0;
  assign carry_clr    = state == DECODE && is_exec && op != 4'd2;
  assign carry_set    = state == DECODE && op == 4'd2;
  assign acc_write_en = state == DECODE && op == 4'd6;
  assign acc_shift_en = ex;
  assign reg_shift_en = ex;
  assign reg_write_en = ex && is_st;
  assign acc_recirc   = ex && is_st;
  assign busy         = state != IDLE;
  assign done         = state == DONE;
  assign illegal      = state == DONE && op > 4'd6;
  assign reg_addr_sel = busy ? instr_q[REG_AW-1:0] : '0;
  assign imm          = instr_q[7:0];
  assign bit_idx      = state == EXEC ? cnt : '0;
endmodule

// File: doc/bit_serial_sequencer.md
Name: bit_serial_sequencer

Overview:
Instruction sequencer for the bit-serial CPU datapath: accumulator shift register, register file, 1-bit ALU and carry flop. It accepts one 12-bit instruction per button press, decodes it, then drives the shift, write, ALU-op and carry controls for exactly WIDTH serial bit cycles, LSB first. It replaces the external execution counter with an internal bit counter and signals completion with a one-cycle done pulse.

Parameters:
WIDTH, 8, datapath width = number of serial bit cycles per ALU instruction (2..16)
REG_AW, 3, register address width (register file depth 2**REG_AW)

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
instr  input  12  instruction word; opcode = instr[11:8], reg field = instr[REG_AW-1:0], immediate = instr[7:0]
instr_valid  input  1  instr is stable and may be accepted
btn_edge  input  1  one-cycle start strobe (debounced button edge)
alu_op  output  2  00 ADD, 01 SUB (a + ~b + cin), 10 AND, 11 OR
carry_clr  output  1  force carry flop to 0 next edge
carry_set  output  1  force carry flop to 1 next edge
reg_addr_sel  output  REG_AW  register file select
reg_shift_en  output  1  rotate selected register one bit
reg_write_en  output  1  shift-in to selected register comes from accumulator serial out
acc_shift_en  output  1  shift accumulator one bit
acc_recirc  output  1  accumulator shift-in = its own serial out (rotate) instead of ALU result
acc_write_en  output  1  parallel load accumulator from imm
imm  output  8  latched immediate
bit_idx  output  $clog2(WIDTH)  current bit index during EXEC, else 0
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse at instruction completion
illegal  output  1  one-cycle pulse coincident with done for an undefined opcode

Behaviour:
- Reset (rstn=0 at posedge): state IDLE, all outputs 0, latched instr 0, bit counter 0. Reset mid-instruction aborts immediately; no partial done.
- States: IDLE, DECODE, EXEC, DONE.
- IDLE: on btn_edge=1 & instr_valid=1 latch instr, go DECODE. btn_edge without instr_valid is ignored. btn_edge in any non-IDLE state is ignored (not queued).
- DECODE (1 cycle): ADD/AND/OR/ST assert carry_clr; SUB asserts carry_set; LDI asserts acc_write_en (imm already valid); NOP/LDI/illegal go DONE; others go EXEC with counter=0.
- Opcodes: 0x0 NOP; 0x1 ADD Rn; 0x2 SUB Rn; 0x3 AND Rn; 0x4 OR Rn; 0x5 ST Rn (Rn <= ACC); 0x6 LDI imm8; 0x7-0xF illegal (treated as NOP, illegal pulses).
- EXEC (WIDTH cycles, bit_idx 0..WIDTH-1): ALU ops assert acc_shift_en=1, reg_shift_en=1 (register rotates, value preserved), reg_write_en=0, acc_recirc=0, alu_op per opcode. ST asserts acc_shift_en=1, acc_recirc=1, reg_shift_en=1, reg_write_en=1. reg_addr_sel = latched reg field, held constant over the whole instruction (IDLE: 0). Leave after bit_idx=WIDTH-1 to DONE.
- DONE (1 cycle): done=1, illegal as applicable, return IDLE. btn_edge in DONE ignored.
- Latency: btn_edge accepted at edge T -> DECODE T+1; ALU/ST ops EXEC T+2..T+WIDTH+1, done at T+WIDTH+2; NOP/LDI/illegal done at T+2.
- All control outputs registered or decoded from registered state only; none combinationally depend on btn_edge or instr.
- carry_clr and carry_set are never asserted together; control outputs are 0 outside the states listed.

Optional Feature:
SEQ_SINGLE_STEP_EN: when defined, EXEC advances one bit only on btn_edge. Shift enables are asserted only in cycles where btn_edge=1, and bit_idx increments then. DECODE and DONE are unchanged. When undefined, EXEC is free-running, one bit per clock, and btn_edge is ignored in EXEC.

Test Plan:
- Reset mid-EXEC (ADD, bit_idx=3) -> next cycle IDLE, busy=0, all enables 0, no done pulse.
- LDI 0x5A (instr=0x65A) + btn_edge -> acc_write_en 1 cycle in DECODE, imm=0x5A, done at T+2, illegal=0.
- ADD R3 (instr=0x103) -> carry_clr in DECODE; 8 cycles with acc_shift_en=reg_shift_en=1, alu_op=00, reg_addr_sel=3, bit_idx 0..7; done at T+10.
- SUB R1 (0x201) -> carry_set in DECODE (not carry_clr), alu_op=01 for 8 cycles; ST R2 (0x502) -> reg_write_en=acc_recirc=1 for 8 cycles.
- Opcode 0xA, plus btn_edge pulses during EXEC and DONE -> illegal and done together at T+2; extra btn_edge ignored, no second instruction starts; instr changed mid-EXEC has no effect on reg_addr_sel.
- With SEQ_SINGLE_STEP_EN: ADD with btn_edge every 3rd cycle -> exactly 8 shift-enable cycles, each coincident with btn_edge, then done.
